// File: rtl/mips_mc_control_unit.sv
// Multicycle MIPS control unit.
// Sequences fetch/decode/execute/memory/writeback and drives every datapath
// enable, mux select and the ALU operation code.
//
// Ports:
//   clk, rst (sync, active low), en (global advance/stall)
//   Opcode, Funct       instruction fields (stable from DECODE onward)
//   MemReady            memory access complete
//   IorD, MemRead, MemWrite, IRWrite, PCWrite, Branch, BranchNe, PCSrc,
//   ALUSrcA, ALUSrcB, ExtSel, ALUControl, RegDst, MemtoReg, RegWrite
//                       datapath controls
//   Illegal             sticky illegal-instruction flag
//   State               current state (debug)
module mips_mc_control_unit #(
  parameter int unsigned MEM_WAIT  = 1,
  parameter int unsigned ALUCTRL_W = 3,
  parameter int unsigned HAS_JAL   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [5:0]           Opcode,
  input  logic [5:0]           Funct,
  input  logic                 MemReady,
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 Branch,
  output logic                 BranchNe,
  output logic [1:0]           PCSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic                 ExtSel,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [1:0]           RegDst,
  output logic [1:0]           MemtoReg,
  output logic                 RegWrite,
  output logic                 Illegal,
  output logic [3:0]           State
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StRtExe  = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StIExe   = 4'd9,
    StIWb    = 4'd10,
    StJump   = 4'd11,
    StJal    = 4'd12,
    StHalt   = 4'd15
  } state_e;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluNor = 4'b1100;

  state_e     state_q, state_d;
  logic       illegal_q;
  logic       mem_ready;
  logic       rtype_legal;
  logic [3:0] rtype_alu;
  logic [3:0] imm_alu;
  logic       imm_zext;
  logic [3:0] alu;
  logic       gate;
  logic       mem_read_raw, mem_write_raw, ir_write_raw, pc_write_raw;
  logic       branch_raw, branch_ne_raw, reg_write_raw;

  assign mem_ready = (MEM_WAIT != 0) ? MemReady : 1'b1;

  // R-type function decode; nor exists only with the wide ALU code.
  always_comb begin
    rtype_legal = 1'b1;
    rtype_alu   = AluAdd;
    case (Funct)
      6'h20: rtype_alu = AluAdd;
      6'h22: rtype_alu = AluSub;
      6'h24: rtype_alu = AluAnd;
      6'h25: rtype_alu = AluOr;
      6'h2A: rtype_alu = AluSlt;
      6'h27: begin
        if (ALUCTRL_W == 4) rtype_alu = AluNor;
        else                rtype_legal = 1'b0;
      end
      default: rtype_legal = 1'b0;
    endcase
  end

  // Immediate ALU decode, reused in IWB since Opcode stays stable.
  always_comb begin
    imm_alu  = AluAdd;
    imm_zext = 1'b0;
    case (Opcode)
      6'h0C: begin imm_alu = AluAnd; imm_zext = 1'b1; end
      6'h0D: begin imm_alu = AluOr;  imm_zext = 1'b1; end
      6'h0A: imm_alu = AluSlt;
      default: imm_alu = AluAdd;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (Opcode)
          6'h23, 6'h2B:               state_d = StMemAdr;
          6'h00:                      state_d = rtype_legal ? StRtExe : StHalt;
          6'h04, 6'h05:               state_d = StBranch;
          6'h08, 6'h0C, 6'h0D, 6'h0A: state_d = StIExe;
          6'h02:                      state_d = StJump;
          6'h03:                      state_d = (HAS_JAL != 0) ? StJal : StHalt;
          default:                    state_d = StHalt;
        endcase
      end
      StMemAdr: state_d = (Opcode == 6'h23) ? StMemRd : StMemWr;
      StMemRd:  if (mem_ready) state_d = StMemWb;
      StMemWb:  state_d = StFetch;
      StMemWr:  if (mem_ready) state_d = StFetch;
      StRtExe:  state_d = StAluWb;
      StAluWb:  state_d = StFetch;
      StBranch: state_d = StFetch;
      StIExe:   state_d = StIWb;
      StIWb:    state_d = StFetch;
      StJump:   state_d = StFetch;
      StJal:    state_d = StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StHalt;  // unused codes 13/14
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      if (state_d == StHalt) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    IorD          = 1'b0;
    PCSrc         = 2'b00;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ExtSel        = 1'b0;
    alu           = AluAdd;
    RegDst        = 2'b00;
    MemtoReg      = 2'b00;
    mem_read_raw  = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    pc_write_raw  = 1'b0;
    branch_raw    = 1'b0;
    branch_ne_raw = 1'b0;
    reg_write_raw = 1'b0;
    case (state_q)
      StFetch: begin
        mem_read_raw = 1'b1;
        ALUSrcB      = 2'b01;
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
      end
      StDecode: ALUSrcB = 2'b11;
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StMemRd: begin
        IorD         = 1'b1;
        mem_read_raw = 1'b1;
      end
      StMemWb: begin
        MemtoReg      = 2'b01;
        reg_write_raw = 1'b1;
      end
      StMemWr: begin
        IorD          = 1'b1;
        mem_write_raw = 1'b1;
      end
      StRtExe: begin
        ALUSrcA = 1'b1;
        alu     = rtype_alu;
      end
      StAluWb: begin
        RegDst        = 2'b01;
        reg_write_raw = 1'b1;
      end
      StBranch: begin
        ALUSrcA       = 1'b1;
        alu           = AluSub;
        PCSrc         = 2'b01;
        branch_raw    = (Opcode == 6'h04);
        branch_ne_raw = (Opcode == 6'h05);
      end
      StIExe: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        alu     = imm_alu;
        ExtSel  = imm_zext;
      end
      StIWb: begin
        alu           = imm_alu;
        ExtSel        = imm_zext;
        reg_write_raw = 1'b1;
      end
      StJump: begin
        PCSrc        = 2'b10;
        pc_write_raw = 1'b1;
      end
      StJal: begin
        PCSrc         = 2'b10;
        pc_write_raw  = 1'b1;
        reg_write_raw = 1'b1;
        RegDst        = 2'b10;
        MemtoReg      = 2'b10;
      end
      default: ;
    endcase
  end

  // Writes and requests are suppressed under reset or stall so no partial
  // transaction can leak out.
  assign gate     = rst & en;
  assign MemRead  = mem_read_raw & gate;
  assign MemWrite = mem_write_raw & gate;
  assign IRWrite  = ir_write_raw & gate;
  assign PCWrite  = pc_write_raw & gate;
  assign Branch   = branch_raw & gate;
  assign BranchNe = branch_ne_raw & gate;
  assign RegWrite = reg_write_raw & gate;

  assign ALUControl = alu[ALUCTRL_W-1:0];
  assign Illegal    = illegal_q;
  assign State      = state_q;

endmodule

// File: tb/tb_mips_mc_control_unit.sv
// Directed bench for mips_mc_control_unit. Two instances share stimulus:
// dut (defaults, 3-bit ALU code, jal) and dut2 (no jal, 4-bit ALU code).
module tb_mips_mc_control_unit;

  logic       clk = 1'b0;
  logic       rst, en, MemReady;
  logic [5:0] Opcode, Funct;

  logic       IorD, MemRead, MemWrite, IRWrite, PCWrite, Branch, BranchNe;
  logic [1:0] PCSrc, ALUSrcB, RegDst, MemtoReg;
  logic       ALUSrcA, ExtSel, RegWrite, Illegal;
  logic [2:0] ALUControl;
  logic [3:0] State;

  logic       b_IorD, b_MemRead, b_MemWrite, b_IRWrite, b_PCWrite, b_Branch, b_BranchNe;
  logic [1:0] b_PCSrc, b_ALUSrcB, b_RegDst, b_MemtoReg;
  logic       b_ALUSrcA, b_ExtSel, b_RegWrite, b_Illegal;
  logic [3:0] b_ALUControl;
  logic [3:0] b_State;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mips_mc_control_unit dut (
    .clk(clk), .rst(rst), .en(en), .Opcode(Opcode), .Funct(Funct), .MemReady(MemReady),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .Branch(Branch), .BranchNe(BranchNe), .PCSrc(PCSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .ALUControl(ALUControl),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .Illegal(Illegal),
    .State(State)
  );

  mips_mc_control_unit #(.MEM_WAIT(1), .ALUCTRL_W(4), .HAS_JAL(0)) dut2 (
    .clk(clk), .rst(rst), .en(en), .Opcode(Opcode), .Funct(Funct), .MemReady(MemReady),
    .IorD(b_IorD), .MemRead(b_MemRead), .MemWrite(b_MemWrite), .IRWrite(b_IRWrite),
    .PCWrite(b_PCWrite), .Branch(b_Branch), .BranchNe(b_BranchNe), .PCSrc(b_PCSrc),
    .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB), .ExtSel(b_ExtSel), .ALUControl(b_ALUControl),
    .RegDst(b_RegDst), .MemtoReg(b_MemtoReg), .RegWrite(b_RegWrite), .Illegal(b_Illegal),
    .State(b_State)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs may be changed afterwards, outputs settle by #1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] enables();
    return {MemRead, MemWrite, IRWrite, PCWrite, Branch, BranchNe, RegWrite};
  endfunction

  task automatic pulse_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; MemReady = 1'b1; Opcode = 6'h00; Funct = 6'h20;
    tick();
    tick();
    check("rst_state", State, 0);
    check("rst_illegal", Illegal, 0);
    check("rst_enables", enables(), 0);

    // R-type add
    rst = 1'b1; #1;
    check("fetch_memread", MemRead, 1);
    check("fetch_irwrite", IRWrite, 1);
    check("fetch_pcwrite", PCWrite, 1);
    check("fetch_alusrcb", ALUSrcB, 2'b01);
    check("fetch_iord", IorD, 0);
    tick(); #1;
    check("r_decode", State, 1);
    check("r_dec_alusrcb", ALUSrcB, 2'b11);
    tick(); #1;
    check("r_rtexe", State, 6);
    check("r_alu_add", ALUControl, 3'b010);
    check("r_rtexe_alusrca", ALUSrcA, 1);
    check("r_rtexe_regwr", RegWrite, 0);
    tick(); #1;
    check("r_aluwb", State, 7);
    check("r_aluwb_regwr", RegWrite, 1);
    check("r_aluwb_regdst", RegDst, 2'b01);
    tick(); #1;
    check("r_back_fetch", State, 0);

    // lw with three MemReady-low cycles in MEMRD
    Opcode = 6'h23;
    tick(); #1;
    check("lw_decode", State, 1);
    tick(); #1;
    check("lw_memadr", State, 2);
    check("lw_memadr_alusrcb", ALUSrcB, 2'b10);
    tick();
    MemReady = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      check("lw_memrd_state", State, 3);
      check("lw_memrd_read", MemRead, 1);
      check("lw_memrd_iord", IorD, 1);
      tick(); #1;
    end
    MemReady = 1'b1; #1;
    check("lw_memrd_last", State, 3);
    tick(); #1;
    check("lw_memwb", State, 4);
    check("lw_memwb_mtr", MemtoReg, 2'b01);
    check("lw_memwb_regwr", RegWrite, 1);
    tick(); #1;
    check("lw_back_fetch", State, 0);

    // ori
    Opcode = 6'h0D;
    tick(); tick(); #1;
    check("ori_iexe", State, 9);
    check("ori_extsel", ExtSel, 1);
    check("ori_alu", ALUControl, 3'b001);
    tick(); #1;
    check("ori_iwb", State, 10);
    check("ori_iwb_regdst", RegDst, 2'b00);
    check("ori_iwb_regwr", RegWrite, 1);
    tick(); #1;

    // bne
    Opcode = 6'h05;
    tick(); tick(); #1;
    check("bne_state", State, 8);
    check("bne_branchne", BranchNe, 1);
    check("bne_branch", Branch, 0);
    check("bne_alu", ALUControl, 3'b110);
    check("bne_pcsrc", PCSrc, 2'b01);
    tick(); #1;
    check("bne_back_fetch", State, 0);

    // jal: legal on dut, illegal on dut2
    Opcode = 6'h03;
    tick(); tick(); #1;
    check("jal_state", State, 12);
    check("jal_pcwrite", PCWrite, 1);
    check("jal_regwrite", RegWrite, 1);
    check("jal_regdst", RegDst, 2'b10);
    check("jal_memtoreg", MemtoReg, 2'b10);
    check("jal_pcsrc", PCSrc, 2'b10);
    check("nojal_state", b_State, 15);
    check("nojal_illegal", b_Illegal, 1);
    check("nojal_pcwrite", b_PCWrite, 0);
    tick(); #1;
    check("jal_back_fetch", State, 0);
    check("nojal_absorb", b_State, 15);
    pulse_reset();
    check("nojal_rst_state", b_State, 0);
    check("nojal_rst_illegal", b_Illegal, 0);

    // nor: legal only with the 4-bit ALU code
    Opcode = 6'h00; Funct = 6'h27;
    tick(); tick(); #1;
    check("nor_w3_halt", State, 15);
    check("nor_w3_illegal", Illegal, 1);
    check("nor_w4_rtexe", b_State, 6);
    check("nor_w4_alu", b_ALUControl, 4'b1100);
    pulse_reset();

    // Unknown opcode halts until reset
    Opcode = 6'h3F; Funct = 6'h20;
    tick(); tick(); #1;
    for (int i = 0; i < 10; i++) begin
      check("halt_state", State, 15);
      check("halt_illegal", Illegal, 1);
      check("halt_enables", enables(), 0);
      tick(); #1;
    end
    pulse_reset();
    check("halt_rst_state", State, 0);
    check("halt_rst_illegal", Illegal, 0);

    // sw with a stall during MEMWR
    Opcode = 6'h2B;
    tick(); tick(); #1;
    check("sw_memadr", State, 2);
    MemReady = 1'b0;
    tick(); #1;
    check("sw_memwr", State, 5);
    check("sw_memwrite", MemWrite, 1);
    check("sw_iord", IorD, 1);
    en = 1'b0; #1;
    check("sw_stall_mw0", MemWrite, 0);
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      check("sw_stall_state", State, 5);
      check("sw_stall_mw", MemWrite, 0);
    end
    en = 1'b1; MemReady = 1'b1; #1;
    check("sw_resume_mw", MemWrite, 1);
    check("sw_resume_state", State, 5);
    tick(); #1;
    check("sw_done_state", State, 0);
    check("sw_done_mw", MemWrite, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_mc_control_unit.md
Name: mips_mc_control_unit

Overview:
- Parametrised next-generation multicycle MIPS control unit for CoreMips.
- A Mealy/Moore FSM that sequences fetch/decode/execute/memory/writeback and produces all datapath enables, mux selects and ALUControl.
- Beyond the base control unit it adds:
  - a variable-latency memory handshake (MemReady);
  - a global stall (en);
  - bne, andi, ori, slti, j and jal;
  - an optional 4-bit ALUControl with nor;
  - a sticky illegal-instruction halt.

Parameters:
- MEM_WAIT, 1: 1 = honour MemReady; 0 = MemReady treated as constant 1.
- ALUCTRL_W, 3: ALUControl width, 3 or 4. At 4, codes are zero-extended and nor = 4'b1100 is enabled.
- HAS_JAL, 1: 0 = opcode 6'h03 is illegal.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- en  in  1  1 = advance; 0 = hold state, all write enables forced 0
- Opcode  in  6  IR[31:26], stable from DECODE onward
- Funct  in  6  IR[5:0]
- MemReady  in  1  memory has completed the current access
- IorD  out  1  0 = PC address, 1 = ALUOut address
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- PCWrite  out  1  unconditional PC load
- Branch  out  1  PC load if Zero
- BranchNe  out  1  PC load if !Zero
- PCSrc  out  2  00 ALUResult, 01 ALUOut, 10 jump target
- ALUSrcA  out  1  0 PC, 1 A
- ALUSrcB  out  2  00 B, 01 const 4, 10 imm, 11 imm<<2
- ExtSel  out  1  0 sign-extend, 1 zero-extend
- ALUControl  out  ALUCTRL_W  ALU operation
- RegDst  out  2  00 rt, 01 rd, 10 $31
- MemtoReg  out  2  00 ALUOut, 01 Data, 10 PC
- RegWrite  out  1  register file write
- Illegal  out  1  sticky illegal-instruction flag
- State  out  4  current state (debug)

Behaviour:
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEXE 6, ALUWB 7, BRANCH 8, IEXE 9, IWB 10, JUMP 11, JAL 12, HALT 15. Codes 13 and 14 fall through to HALT.
- Reset and stall:
  - rst=0 at a rising edge: State<=FETCH, Illegal<=0.
  - While rst=0 or en=0, every write/request output (MemRead, MemWrite, IRWrite, PCWrite, Branch, BranchNe, RegWrite) is 0 and State holds (except under reset).
  - All selects default to 0 and ALUControl defaults to add (010) wherever a state leaves them unspecified.
- ALU codes: and 000, or 001, add 010, sub 110, slt 111, nor 1100 (ALUCTRL_W=4 only).
- Per-state outputs and transitions; each transition is taken only with en=1:
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, add, PCSrc=00.
    - IRWrite=PCWrite=MemReady.
    - Goes to DECODE when MemReady=1, otherwise stays in FETCH.
  - DECODE: ALUSrcA=0, ALUSrcB=11, add. Dispatch on Opcode:
    - 23/2B → MEMADR
    - 00 with legal Funct → RTEXE
    - 04/05 → BRANCH
    - 08/0C/0D/0A → IEXE
    - 02 → JUMP
    - 03 → JAL (only if HAS_JAL)
    - anything else → HALT
  - R-type legal Funct values: 20 add, 22 sub, 24 and, 25 or, 2A slt, 27 nor (ALUCTRL_W=4 only).
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ExtSel=0, add. Goes to MEMRD if Opcode=23, else MEMWR.
  - MEMRD: IorD=1, MemRead=1. Goes to MEMWB when MemReady=1.
  - MEMWB: RegDst=00, MemtoReg=01, RegWrite=1. Goes to FETCH.
  - MEMWR: IorD=1, MemWrite=1, held until MemReady=1, then goes to FETCH. MemWrite drops in the cycle after MemReady.
  - RTEXE: ALUSrcA=1, ALUSrcB=00, ALUControl from Funct. Goes to ALUWB.
  - ALUWB: RegDst=01, MemtoReg=00, RegWrite=1. Goes to FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01. Branch=1 for opcode 04, BranchNe=1 for opcode 05. Goes to FETCH.
  - IEXE: ALUSrcA=1, ALUSrcB=10. ALUControl is add/and/or/slt for 08/0C/0D/0A. ExtSel=1 only for 0C and 0D. Goes to IWB.
  - IWB: RegDst=00, MemtoReg=00, RegWrite=1; ExtSel and ALUControl held from IEXE. Goes to FETCH.
  - JUMP: PCSrc=10, PCWrite=1. Goes to FETCH.
  - JAL: PCSrc=10, PCWrite=1, RegWrite=1, RegDst=10, MemtoReg=10 (PC already holds PC+4). Goes to FETCH.
  - HALT: Illegal=1 (registered, set on entry), all enables 0. Absorbing until rst=0.
- Latency with MemReady constantly 1 (cycles per instruction): lw 5, sw 4, R-type 4, I-ALU 4, branch 3, j 3, jal 3.
- Each wait cycle with MemReady=0 adds 1 cycle in FETCH, MEMRD or MEMWR.
- en=0 during a memory wait: request outputs drop to 0 and the access restarts when en returns.
- Reset mid-instruction: the next edge returns to FETCH. No partial writes occur because the enables are gated by rst.

Test Plan:
- Reset, then en=1, MemReady=1, Opcode=00, Funct=20 → State 0,1,6,7,0. RegWrite=1 only in ALUWB, with RegDst=01 and ALUControl=010 in RTEXE.
- lw (Opcode=23) with MemReady low for 3 cycles in MEMRD → State stays 3 for 3 cycles, MemRead=1 and IorD=1 throughout. MEMWB follows with MemtoReg=01 and RegWrite=1; 8 cycles total.
- ori (0D) → in IEXE, ExtSel=1 and ALUControl=001; IWB has RegDst=00 and RegWrite=1. Then bne (05) → BranchNe=1, Branch=0, ALUControl=110, PCSrc=01.
- jal (03), HAS_JAL=1 → JAL state with PCWrite=1, RegWrite=1, RegDst=10, MemtoReg=10, PCSrc=10. Repeat with HAS_JAL=0 → HALT with Illegal=1.
- Opcode=3F → HALT and Illegal=1, which persists for 10 cycles with all enables 0. rst=0 for one edge → State=0, Illegal=0.
- en=0 for 2 cycles in MEMWR → MemWrite=0 and State=5 held. After en=1 and MemReady=1 → MemWrite=1 for one cycle, then State=0.
